// File: rtl/serial_loader.sv
// serial_loader: 8N1 UART host link that issues 16-bit-address byte reads/writes on a simple req/ack bus.
// Define LOADER_CHECKSUM_EN to add an 8-bit additive checksum to both frame directions.
module serial_loader #(
    parameter int clk_freq_hz    = 27_000_000,
    parameter int baud_rate      = 115200,
    parameter int oversample     = 16,
    parameter int timeout_cycles = 27_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);
    localparam int BAUD_DIV = clk_freq_hz / (baud_rate * oversample);
    localparam logic [7:0] ACK = 8'h06, NAK = 8'h15, CMD_W = 8'h57, CMD_R = 8'h52;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    typedef enum logic [3:0] {IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WBUS, RBUS, RSEND, CSUM, REPLY} state_t;
    state_t state, state_n;
    logic [15:0] baud_cnt;
    logic        tick;
    logic        rx_meta, rx_s, rx_busy, rx_err, hold_full;
    logic [7:0]  rx_cnt, rx_sh, hold;
    logic [3:0]  rx_bit;
    logic [9:0]  tx_sh;
    logic [3:0]  tx_bits;
    logic [7:0]  tx_cnt, tx_byte;
    logic        tx_busy, tx_load;
    logic        rx_take, flush, fsm_err, err_q, cmd_w, cmd_ok, waiting, timed_out, rep_pending;
    logic [8:0]  cnt;
    logic [7:0]  rdata, rep_byte, csum;
    logic [31:0] tcnt;

    assign tick = baud_cnt == 16'(BAUD_DIV - 1);
    assign tx = tx_sh[0];
    assign busy = state != IDLE;
    assign err = err_q | rx_err;
    assign cmd_ok = hold == CMD_W || hold == CMD_R;
    assign flush = state == REPLY && state_n == IDLE;
    assign waiting = (state == ADDR_HI || state == ADDR_LO || state == LEN || state == WDATA || state == CSUM) && !hold_full;
    assign timed_out = waiting && tcnt == 32'(timeout_cycles - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) baud_cnt <= '0;
        else baud_cnt <= tick ? '0 : baud_cnt + 16'd1;

    // Receiver: first sample lands mid start bit, then one sample per bit period.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rx_meta <= 1'b1; rx_s <= 1'b1; rx_busy <= 1'b0; rx_err <= 1'b0;
            rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; hold <= '0; hold_full <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s <= rx_meta;
            rx_err <= 1'b0;
            if (rx_take || flush) hold_full <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt <= 8'(oversample / 2 - 1);
                    rx_bit <= '0;
                end
            end else if (tick) begin
                if (rx_cnt != 8'd0) rx_cnt <= rx_cnt - 8'd1;
                else begin
                    rx_cnt <= 8'(oversample - 1);
                    rx_bit <= rx_bit + 4'd1;
                    if (rx_bit == 4'd0) rx_busy <= !rx_s;
                    else if (rx_bit == 4'd9) begin
                        rx_busy <= 1'b0;
                        if (!rx_s || (hold_full && !rx_take)) rx_err <= 1'b1;
                        else begin
                            hold <= rx_sh;
                            hold_full <= 1'b1;
                        end
                    end else rx_sh <= {rx_s, rx_sh[7:1]};
                end
            end
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tx_sh <= '1; tx_bits <= '0; tx_cnt <= '0; tx_busy <= 1'b0;
        end else if (tx_load) begin
            tx_sh <= {1'b1, tx_byte, 1'b0};
            tx_bits <= 4'd10;
            tx_cnt <= 8'(oversample - 1);
            tx_busy <= 1'b1;
        end else if (tx_busy && tick) begin
            if (tx_cnt != 8'd0) tx_cnt <= tx_cnt - 8'd1;
            else begin
                tx_cnt <= 8'(oversample - 1);
                tx_sh <= {1'b1, tx_sh[9:1]};
                tx_bits <= tx_bits - 4'd1;
                tx_busy <= tx_bits != 4'd1;
            end
        end

    always_comb begin
        state_n = state;
        rx_take = 1'b0;
        tx_load = 1'b0;
        tx_byte = rdata;
        fsm_err = 1'b0;
        case (state)
            IDLE: if (hold_full && !tx_busy) begin
                rx_take = 1'b1;
                state_n = cmd_ok ? ADDR_HI : IDLE;
                tx_load = !cmd_ok;
                tx_byte = NAK;
                fsm_err = !cmd_ok;
            end
            ADDR_HI: if (hold_full) begin rx_take = 1'b1; state_n = ADDR_LO; end
            ADDR_LO: if (hold_full) begin rx_take = 1'b1; state_n = LEN; end
            LEN:     if (hold_full) begin rx_take = 1'b1; state_n = cmd_w ? WDATA : RBUS; end
            WDATA:   if (hold_full) begin rx_take = 1'b1; state_n = WBUS; end
            CSUM:    if (hold_full) begin rx_take = 1'b1; state_n = REPLY; fsm_err = hold != csum; end
            WBUS:    if (mem_ack) state_n = cnt != 9'd1 ? WDATA : CSUM_EN ? CSUM : REPLY;
            RBUS:    if (mem_ack) state_n = RSEND;
            RSEND: if (!tx_busy) begin
                tx_load = 1'b1;
                state_n = cnt == 9'd0 ? REPLY : RBUS;
            end
            REPLY: if (!tx_busy) begin
                tx_load = rep_pending;
                tx_byte = rep_byte;
                state_n = rep_pending ? REPLY : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timed_out) begin
            state_n = IDLE;
            fsm_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE; mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
            cmd_w <= 1'b0; cnt <= '0; rdata <= '0; rep_byte <= ACK; rep_pending <= 1'b0;
            tcnt <= '0; err_q <= 1'b0; csum <= '0;
        end else begin
            state <= state_n;
            mem_req <= state_n == WBUS || state_n == RBUS;
            mem_we <= state_n == WBUS;
            err_q <= fsm_err;
            tcnt <= waiting ? tcnt + 32'd1 : '0;
            if (rx_take)
                case (state)
                    IDLE:    cmd_w <= hold == CMD_W;
                    ADDR_HI: mem_addr[15:8] <= hold;
                    ADDR_LO: mem_addr[7:0] <= hold;
                    LEN: begin
                        cnt <= {hold == 8'd0, hold};
                        rep_byte <= ACK;
                        rep_pending <= CSUM_EN || cmd_w;
                    end
                    WDATA:   mem_wdata <= hold;
                    CSUM:    rep_byte <= hold == csum ? ACK : NAK;
                    default: ;
                endcase
            if ((state == WBUS || state == RBUS) && mem_ack) begin
                mem_addr <= mem_addr + 16'd1;
                cnt <= cnt - 9'd1;
                if (state == RBUS) rdata <= mem_rdata;
            end
            if (state == RSEND && tx_load && cnt == 9'd0) rep_byte <= csum;
            if (state == REPLY && tx_load) rep_pending <= 1'b0;
            // Running checksum covers header and data bytes in either direction.
            if (state == IDLE) csum <= '0;
            else if (rx_take && state != CSUM) csum <= csum + hold;
            else if (state == RBUS && mem_ack) csum <= csum + mem_rdata;
        end
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: drives host frames over serial, models the memory bus and checks replies/transfers.
module tb_serial_loader;
    localparam int BIT = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic tx, mem_req, mem_we, busy, err;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata;

    serial_loader #(
        .clk_freq_hz(8_000_000), .baud_rate(1_000_000), .oversample(8), .timeout_cycles(5000)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} op_t;
    op_t exp_bus[$];
    logic [7:0] exp_tx[$], got[$];
    logic [7:0] bus_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] wdat [0:255];
    logic [7:0] last_cs;
    int tests = 0, fails = 0, errs = 0, lat = 0;
    logic pv_we;
    logic [15:0] pv_a;
    logic [7:0] pv_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [15:0] a);
        return 8'(a[7:0] + 3 * a[15:8] + 8'h11);
    endfunction

    // Bus responder with programmable ack latency; also the per-cycle protocol checker.
    initial begin
        int w;
        op_t e;
        w = 0;
        forever begin
            @(negedge clk);
            mem_rdata = 8'($urandom);
            if (!rst) begin
                mem_ack = 1'b0;
                w = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                chk("req_drop_after_ack", mem_req, 0);
            end else if (mem_req) begin
                if (w > 0) chk("req_stable", {mem_we, mem_addr, mem_wdata}, {pv_we, pv_a, pv_d});
                pv_we = mem_we; pv_a = mem_addr; pv_d = mem_wdata;
                if (w >= lat) begin
                    mem_ack = 1'b1;
                    w = 0;
                    chk("bus_pending", 32'(exp_bus.size() != 0), 1);
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        chk("bus_we", mem_we, e.we);
                        chk("bus_addr", mem_addr, e.addr);
                        if (e.we) chk("bus_wdata", mem_wdata, e.data);
                    end
                    if (mem_we) bus_mem[mem_addr] = mem_wdata;
                    else mem_rdata = bus_mem[mem_addr];
                end else w++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (err === 1'b1) errs++;
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BIT) @(negedge clk);
                    chk("tx_stop_bit", tx, 1);
                    got.push_back(b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic compare_reply(input int e0, input int exp_err);
        chk("reply_len", got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < got.size(); i++) chk("reply_byte", got[i], exp_tx[i]);
        chk("bus_left", exp_bus.size(), 0);
        chk("err_count", errs - e0, exp_err);
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] len, input logic bad);
        int n, e0, t, budget;
        logic [7:0] cs;
        logic [15:0] ai;
        n = len == 8'd0 ? 256 : int'(len);
        cs = a[15:8] + a[7:0] + len;
        e0 = errs;
        got.delete();
        exp_tx.delete();
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            if (cmd == 8'h57) begin
                exp_bus.push_back({1'b1, ai, wdat[i]});
                ref_mem[ai] = wdat[i];
                cs += wdat[i];
            end else begin
                exp_bus.push_back({1'b0, ai, ref_mem[ai]});
                exp_tx.push_back(ref_mem[ai]);
                cs += ref_mem[ai];
            end
        end
        last_cs = cs;
        if (cmd == 8'h57) exp_tx.push_back((CS_EN && bad) ? 8'h15 : 8'h06);
        else if (CS_EN) exp_tx.push_back(cs);
        send_byte(cmd);
        send_byte(a[15:8]);
        chk("busy_in_frame", busy, 1);
        send_byte(a[7:0]);
        send_byte(len);
        if (cmd == 8'h57) begin
            for (int i = 0; i < n; i++) send_byte(wdat[i]);
            if (CS_EN) send_byte(cs + 8'(bad));
        end
        budget = n * 100 + 3000;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("busy_drop_bound", 32'(t < budget), 1);
        chk("bytes_at_busy_drop", got.size(), exp_tx.size());
        repeat (2 * 10 * BIT) @(negedge clk);
        compare_reply(e0, (cmd == 8'h57 && CS_EN && bad) ? 1 : 0);
    endtask

    initial begin
        int e0, t;
        #900_000;
        $display("FAIL watchdog: simulation did not complete, got %0d tests expected completion", tests);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, t;
        for (int a = 0; a < 65536; a++) begin
            bus_mem[a] = pat(16'(a));
            ref_mem[a] = pat(16'(a));
        end
        repeat (5) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Reset in the middle of a frame, then a normal read.
        send_byte(8'h52);
        send_byte(8'h00);
        chk("busy_before_reset", busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        lat = 1;
        do_frame(8'h52, 16'h0100, 8'd3, 1'b0);

        lat = 3;
        wdat[0] = 8'hAA;
        wdat[1] = 8'h55;
        do_frame(8'h57, 16'h1234, 8'd2, 1'b0);
        chk("w_mem_1234", bus_mem[16'h1234], 8'hAA);
        chk("w_mem_1235", bus_mem[16'h1235], 8'h55);
        chk("w_ack_literal", got.size() > 0 ? 32'(got[got.size() - 1]) : 32'hdead, 8'h06);

        lat = 2;
        do_frame(8'h52, 16'hFFFF, 8'd2, 1'b0);
        chk("r_wrap_model_ffff", exp_tx[0], 8'h0D);
        chk("r_wrap_model_0000", exp_tx[1], 8'h11);

        lat = 0;
        do_frame(8'h52, 16'h0000, 8'd0, 1'b0);
        chk("r256_count", got.size(), CS_EN ? 257 : 256);

        e0 = errs;
        got.delete();
        send_byte(8'h41);
        t = 0;
        while (got.size() == 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (4 * BIT) @(negedge clk);
        chk("nak_len", got.size(), 1);
        chk("nak_byte", got.size() > 0 ? 32'(got[0]) : 32'hdead, 8'h15);
        chk("nak_err", errs - e0, 1);
        chk("nak_busy", busy, 0);

        e0 = errs;
        got.delete();
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (4000) @(negedge clk);
        chk("timeout_still_busy", busy, 1);
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_abort_bound", 32'(t < 3000), 1);
        repeat (200) @(negedge clk);
        chk("timeout_no_tx", got.size(), 0);
        chk("timeout_err", errs - e0, 1);

        if (CS_EN) begin
            lat = 1;
            wdat[0] = 8'h07;
            do_frame(8'h57, 16'h0010, 8'd1, 1'b0);
            chk("cs_model", last_cs, 8'h18);
            chk("cs_ack", got.size() > 0 ? 32'(got[0]) : 32'hdead, 8'h06);
            wdat[0] = 8'h07;
            bus_mem[16'h0010] = 8'h00;
            do_frame(8'h57, 16'h0010, 8'd1, 1'b1);
            chk("cs_nak", got.size() > 0 ? 32'(got[0]) : 32'hdead, 8'h15);
            chk("cs_nak_written", bus_mem[16'h0010], 8'h07);
        end

        for (int k = 0; k < 8; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFE;
            lat = $urandom_range(0, 3);
            for (int i = 0; i < 256; i++) wdat[i] = 8'($urandom);
            do_frame($urandom_range(0, 1) != 0 ? 8'h57 : 8'h52, a, 8'($urandom_range(1, 6)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
